ld_mode_sequencer: RTL and testbench



---
 rtl/ld_mode_sequencer_if.sv | 30 +++
 rtl/ld_mode_sequencer.sv | 169 ++++++++++++++++
 tb/tb_ld_mode_sequencer.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ld_mode_sequencer_if.sv
// Requester/core bundle for ld_mode_sequencer.
// Requesters drive req/cmd/code; the sequencer drives grant, done and core selects.
interface ld_mode_sequencer_if #(
  parameter int NREQ   = 4,
  parameter int DATA_W = 5
);
  logic [NREQ-1:0]        req;
  logic [2*NREQ-1:0]      cmd;
  logic [DATA_W*NREQ-1:0] code;
  logic [NREQ-1:0]        gnt;
  logic [NREQ-1:0]        done;
  logic                   busy;
  logic                   s0;
  logic                   s1;
  logic                   s2;
  logic                   s3;
  logic [DATA_W-1:0]      inp;

  modport master (
    output req, cmd, code,
    input  gnt, done, busy,
    input  s0, s1, s2, s3, inp
  );

  modport slave (
    input  req, cmd, code,
    output gnt, done, busy,
    output s0, s1, s2, s3, inp
  );
endinterface

// File: rtl/ld_mode_sequencer.sv
// Round-robin sharing of the LD core mode selects and inp among NREQ requesters.
// Define LD_SEQ_FIXED_PRIORITY_EN for fixed priority (requester 0 highest).
module ld_mode_sequencer #(
  parameter int NREQ        = 4,
  parameter int DATA_W      = 5,
  parameter int HOLD_CYCLES = 1
) (
  input logic                clk,
  input logic                rst,
  ld_mode_sequencer_if.slave bus
);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DRIVE,
    S_GAP
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [CW-1:0]       r_cnt;
  logic [IW-1:0]       w_ptr;
  logic [IW-1:0]       w_win;
  logic                w_any;
  logic                w_grant;
  logic [NREQ-1:0]     r_gnt, w_gnt;
  logic [NREQ-1:0]     r_done, w_done;
  logic                r_busy, w_busy;
  logic [3:0]          r_sel, w_sel;
  logic [DATA_W-1:0]   r_inp, w_inp;
  logic [1:0]          w_cmd_a  [NREQ];
  logic [DATA_W-1:0]   w_code_a [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign w_cmd_a[g]  = bus.cmd[2*g +: 2];
    assign w_code_a[g] = bus.code[DATA_W*g +: DATA_W];
  end

  // cmd -> {s3,s2,s1,s0}
  function automatic logic [3:0] f_dec(input logic [1:0] c);
    case (c)
      2'b00:   return 4'b0010;
      2'b01:   return 4'b0100;
      2'b10:   return 4'b0001;
      default: return 4'b1000;
    endcase
  endfunction

  assign w_any   = |bus.req;
  assign w_grant = (r_state != S_DRIVE) && w_any;

`ifdef LD_SEQ_FIXED_PRIORITY_EN
  assign w_ptr = '0;
`else
  logic [IW-1:0] r_rr_ptr;

  // served requester becomes lowest priority
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rr_ptr <= '0;
    end else if (w_grant) begin
      r_rr_ptr <= (w_win == IW'(NREQ-1)) ? '0 : w_win + IW'(1);
    end
  end

  assign w_ptr = r_rr_ptr;
`endif

  // first requester at or after the pointer, wrapping
  always_comb begin
    logic          found;
    logic [IW:0]   sum;
    logic [IW-1:0] idx;
    found = 1'b0;
    w_win = '0;
    sum   = '0;
    idx   = '0;
    for (int i = 0; i < NREQ; i++) begin
      sum = {1'b0, w_ptr} + (IW+1)'(i);
      if (sum >= (IW+1)'(NREQ)) sum = sum - (IW+1)'(NREQ);
      idx = sum[IW-1:0];
      if (!found && bus.req[idx]) begin
        found = 1'b1;
        w_win = idx;
      end
    end
  end

  // state and hold counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_grant)
        r_cnt <= CW'(HOLD_CYCLES-1);
      else if (r_state == S_DRIVE && r_cnt != '0)
        r_cnt <= r_cnt - CW'(1);
    end
  end

  // next state
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_any) w_state_nxt = S_DRIVE;
      S_DRIVE: if (r_cnt == '0) w_state_nxt = S_GAP;
      S_GAP:   w_state_nxt = w_any ? S_DRIVE : S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // next outputs; the registered sel/inp double as the latched command
  always_comb begin
    w_gnt  = '0;
    w_done = '0;
    w_busy = 1'b0;
    w_sel  = '0;
    w_inp  = '0;
    case (w_state_nxt)
      S_DRIVE: begin
        w_busy = 1'b1;
        if (r_state == S_DRIVE) begin
          w_gnt = r_gnt;
          w_sel = r_sel;
          w_inp = r_inp;
        end else begin
          w_gnt[w_win] = 1'b1;
          w_sel        = f_dec(w_cmd_a[w_win]);
          w_inp        = w_code_a[w_win];
        end
      end
      S_GAP: begin
        w_busy = 1'b1;
        w_done = r_gnt;
      end
      default: ;
    endcase
  end

  // output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_gnt  <= '0;
      r_done <= '0;
      r_busy <= 1'b0;
      r_sel  <= '0;
      r_inp  <= '0;
    end else begin
      r_gnt  <= w_gnt;
      r_done <= w_done;
      r_busy <= w_busy;
      r_sel  <= w_sel;
      r_inp  <= w_inp;
    end
  end

  assign bus.gnt  = r_gnt;
  assign bus.done = r_done;
  assign bus.busy = r_busy;
  assign bus.s0   = r_sel[0];
  assign bus.s1   = r_sel[1];
  assign bus.s2   = r_sel[2];
  assign bus.s3   = r_sel[3];
  assign bus.inp  = r_inp;
endmodule

// File: tb/tb_ld_mode_sequencer.sv
// Scoreboard bench for ld_mode_sequencer at HOLD_CYCLES 1, 2 and 3.
// Define LD_SEQ_FIXED_PRIORITY_EN on both RTL and bench for the fixed-priority build.
module tb_ld_mode_sequencer;
  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  ld_mode_sequencer_if #(.NREQ(4), .DATA_W(5)) b0 ();
  ld_mode_sequencer_if #(.NREQ(4), .DATA_W(5)) b1 ();
  ld_mode_sequencer_if #(.NREQ(4), .DATA_W(5)) b2 ();

  ld_mode_sequencer #(.NREQ(4), .DATA_W(5), .HOLD_CYCLES(1))
    u0 (.clk(clk), .rst(rst), .bus(b0));
  ld_mode_sequencer #(.NREQ(4), .DATA_W(5), .HOLD_CYCLES(2))
    u1 (.clk(clk), .rst(rst), .bus(b1));
  ld_mode_sequencer #(.NREQ(4), .DATA_W(5), .HOLD_CYCLES(3))
    u2 (.clk(clk), .rst(rst), .bus(b2));

  typedef struct {
    int          dut;
    logic [17:0] v;
    string       tag;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   errors  = 0;
  int   m_ptr   = 0;

  // expected {s3,s2,s1,s0} for a command
  function automatic logic [3:0] dec(input logic [1:0] c);
    case (c)
      2'b00:   return 4'b0010;
      2'b01:   return 4'b0100;
      2'b10:   return 4'b0001;
      default: return 4'b1000;
    endcase
  endfunction

  // arbitration model for b0; updates the pointer on grant
  function automatic int pick(input logic [3:0] r);
    int start;
`ifdef LD_SEQ_FIXED_PRIORITY_EN
    start = 0;
`else
    start = m_ptr;
`endif
    for (int i = 0; i < 4; i++) begin
      int k;
      k = (start + i) % 4;
      if (r[k]) begin
        m_ptr = (k + 1) % 4;
        return k;
      end
    end
    return 0;
  endfunction

  function automatic logic [17:0] obs(input int d);
    case (d)
      0: return {b0.gnt, b0.done, b0.busy,
                 b0.s3, b0.s2, b0.s1, b0.s0, b0.inp};
      1: return {b1.gnt, b1.done, b1.busy,
                 b1.s3, b1.s2, b1.s1, b1.s0, b1.inp};
      default: return {b2.gnt, b2.done, b2.busy,
                       b2.s3, b2.s2, b2.s1, b2.s0, b2.inp};
    endcase
  endfunction

  function automatic void push(input int d, input logic [3:0] g,
                               input logic [3:0] dn, input logic b,
                               input logic [3:0] s, input logic [4:0] in,
                               input string t);
    exp_t e;
    e.dut = d;
    e.v   = {g, dn, b, s, in};
    e.tag = t;
    sb.push_back(e);
  endfunction

  function automatic void push_idle(input int d, input string t);
    push(d, 4'b0, 4'b0, 1'b0, 4'b0, 5'b0, t);
  endfunction

  task automatic cmp();
    exp_t        e;
    logic [17:0] o;
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL sb_empty observed=none expected=entry");
      return;
    end
    e = sb.pop_front();
    o = obs(e.dut);
    vectors++;
    assert (o === e.v) else begin
      errors++;
      $error("FAIL %s dut%0d observed=%h expected=%h",
             e.tag, e.dut, o, e.v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cmp();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          w;
    logic [3:0]  g;
    rst = 1'b1;
    b0.req = '0; b0.cmd = '0; b0.code = '0;
    b1.req = '0; b1.cmd = '0; b1.code = '0;
    b2.req = '0; b2.cmd = '0; b2.code = '0;

    // reset state
    @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      push_idle(d, "reset");
      cmp();
    end
    @(negedge clk);
    rst = 1'b0;

    // single load on requester 0
    b0.req       = 4'b0001;
    b0.cmd[1:0]  = 2'b00;
    b0.code[4:0] = 5'b11111;
    w = pick(b0.req);
    g = 4'(1 << w);
    push(0, g, 4'b0, 1'b1, 4'b0010, 5'b11111, "t2_drive");
    tick();
    push(0, 4'b0, g, 1'b1, 4'b0, 5'b0, "t2_gap");
    tick();
    b0.req = '0;
    push_idle(0, "t2_idle");
    tick();

    // hold 3, code change after grant ignored
    b2.req         = 4'b0100;
    b2.cmd[5:4]    = 2'b10;
    b2.code[14:10] = 5'b10101;
    push(2, 4'b0100, 4'b0, 1'b1, 4'b0001, 5'b10101, "t4_drive0");
    tick();
    b2.code[14:10] = 5'b0;
    b2.cmd[5:4]    = 2'b11;
    push(2, 4'b0100, 4'b0, 1'b1, 4'b0001, 5'b10101, "t4_drive1");
    tick();
    push(2, 4'b0100, 4'b0, 1'b1, 4'b0001, 5'b10101, "t4_drive2");
    tick();
    push(2, 4'b0, 4'b0100, 1'b1, 4'b0, 5'b0, "t4_gap");
    tick();
    b2.req = '0;
    push_idle(2, "t4_idle");
    tick();

    // hold 2, req dropped mid-drive
    b1.req       = 4'b0010;
    b1.cmd[3:2]  = 2'b00;
    b1.code[9:5] = 5'd7;
    push(1, 4'b0010, 4'b0, 1'b1, 4'b0010, 5'd7, "t5_drive0");
    tick();
    b1.req = '0;
    push(1, 4'b0010, 4'b0, 1'b1, 4'b0010, 5'd7, "t5_drive1");
    tick();
    push(1, 4'b0, 4'b0010, 1'b1, 4'b0, 5'b0, "t5_gap");
    tick();
    push_idle(1, "t5_idle");
    tick();

    // reset in the middle of a drive
    b2.req          = 4'b1000;
    b2.cmd[7:6]     = 2'b11;
    b2.code[19:15]  = 5'd9;
    push(2, 4'b1000, 4'b0, 1'b1, 4'b1000, 5'd9, "t1_drive");
    tick();
    #2;
    rst = 1'b1;
    #1;
    for (int d = 0; d < 3; d++) begin
      push_idle(d, "t1_rst");
      cmp();
    end
    b2.req = '0;
    m_ptr  = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    push_idle(2, "t1_post0");
    tick();
    push_idle(2, "t1_post1");
    tick();

    // all requesting, back to back
    b0.req  = 4'b1111;
`ifdef LD_SEQ_FIXED_PRIORITY_EN
    b0.cmd  = 8'b01010111;
`else
    b0.cmd  = 8'b01010101;
`endif
    b0.code = {5'd4, 5'd3, 5'd2, 5'd1};
    for (int n = 0; n < 5; n++) begin
      w = pick(b0.req);
      g = 4'(1 << w);
      push(0, g, 4'b0, 1'b1, dec(b0.cmd[2*w +: 2]),
           b0.code[5*w +: 5], "t3_drive");
      tick();
      push(0, 4'b0, g, 1'b1, 4'b0, 5'b0, "t3_gap");
      tick();
    end
    b0.req = '0;
    push_idle(0, "t3_idle");
    tick();

    // pointer kept across idle
    b0.req = 4'b0101;
    w = pick(b0.req);
    g = 4'(1 << w);
    push(0, g, 4'b0, 1'b1, dec(b0.cmd[2*w +: 2]),
         b0.code[5*w +: 5], "t7_drive");
    tick();
    push(0, 4'b0, g, 1'b1, 4'b0, 5'b0, "t7_gap");
    tick();
    b0.req = '0;
    push_idle(0, "t7_idle");
    tick();

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, errors);
    $finish;
  end
endmodule
